// File: rtl/card_dealer.sv
`timescale 1ns/1ps
// card_dealer
//   Shoe stage feeding the hand-scoring card manager. After reset (or a
//   shuffle request) it fills a NUM_DECKS x 52-card shoe, Fisher-Yates
//   shuffles it using a free-running 16-bit Galois LFSR, then deals one
//   card value (1..10) per accepted draw. A dealt card is held on `card`
//   until `card_taken`, after which `card` returns to 0 ("no card").
//
// Ports
//   clk         in   1  clock, all state on posedge
//   reset       in   1  synchronous active-low reset
//   shuffle     in   1  rebuild + reshuffle request (honoured in READY only)
//   draw        in   1  request next card
//   card_taken  in   1  consumer acknowledge, clears card/card_valid
//   card        out  4  dealt value 1..10, 0 = no card
//   card_valid  out  1  card holds an unacknowledged value
//   ready       out  1  shoe shuffled, draws accepted
//   empty       out  1  ready and no cards left
//   cards_left  out  8  undealt cards in shoe
module card_dealer #(
  parameter int          NUM_DECKS = 1,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shuffle,
  input  logic       draw,
  input  logic       card_taken,
  output logic [3:0] card,
  output logic       card_valid,
  output logic       ready,
  output logic       empty,
  output logic [7:0] cards_left
);

  localparam int N  = 52 * NUM_DECKS;
  localparam int AW = $clog2(N);

  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);
  localparam logic [7:0]    FULL    = 8'(N);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    S_FILL,
    S_SHUFFLE,
    S_READY
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;     // fill index in FILL, swap index i in SHUFFLE
  logic [3:0]    rank_q, rank_d;   // idx mod 13, avoids a divider
  logic [AW-1:0] top_q, top_d;     // next card to deal
  logic [15:0]   lfsr_q, lfsr_d;
  logic [3:0]    card_q, card_d;
  logic          card_valid_q, card_valid_d;
  logic [7:0]    cards_left_q, cards_left_d;
  logic [3:0]    deck_q [N];
  logic [3:0]    deck_d [N];

  logic [15:0]   prod;
  logic [AW-1:0] j;

  always_comb begin
    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so every path is covered and no latch forms.
    state_d      = state_q;
    idx_d        = idx_q;
    rank_d       = rank_q;
    top_d        = top_q;
    card_d       = card_q;
    card_valid_d = card_valid_q;
    cards_left_d = cards_left_q;
    deck_d       = deck_q;

    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Scaled random pick: (r * (i+1)) >> 8 lands in 0..i without a modulo.
    prod = {8'h00, lfsr_q[7:0]} * (16'(idx_q) + 16'd1);
    j    = AW'(prod >> 8);

    unique case (state_q)
      S_FILL: begin
        card_d       = 4'd0;
        card_valid_d = 1'b0;
        deck_d[idx_q] = (rank_q >= 4'd9) ? 4'd10 : rank_q + 4'd1;
        rank_d        = (rank_q == 4'd12) ? 4'd0 : rank_q + 4'd1;
        if (idx_q == LAST) begin
          state_d = S_SHUFFLE;
          idx_d   = LAST;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      S_SHUFFLE: begin
        card_d        = 4'd0;
        card_valid_d  = 1'b0;
        deck_d[idx_q] = deck_q[j];
        deck_d[j]     = deck_q[idx_q];
        idx_d         = idx_q - IDX_ONE;
        if (idx_q == IDX_ONE) begin
          state_d      = S_READY;
          top_d        = '0;
          cards_left_d = FULL;
        end
      end

      S_READY: begin
        if (shuffle) begin
          // Reshuffle wins over draw/ack; LFSR keeps running for fresh order.
          state_d      = S_FILL;
          idx_d        = '0;
          rank_d       = 4'd0;
          top_d        = '0;
          card_d       = 4'd0;
          card_valid_d = 1'b0;
          cards_left_d = 8'd0;
        end else begin
          if (card_taken) begin
            card_d       = 4'd0;
            card_valid_d = 1'b0;
          end
          // Gated on the registered valid: a draw in the same cycle as the
          // ack is still ignored.
          if (draw && !card_valid_q && (cards_left_q != 8'd0)) begin
            card_d       = deck_q[top_q];
            card_valid_d = 1'b1;
            top_d        = top_q + IDX_ONE;
            cards_left_d = cards_left_q - 8'd1;
          end
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_FILL;
      idx_q        <= '0;
      rank_q       <= 4'd0;
      top_q        <= '0;
      lfsr_q       <= SEED_EFF;
      card_q       <= 4'd0;
      card_valid_q <= 1'b0;
      cards_left_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rank_q       <= rank_d;
      top_q        <= top_d;
      lfsr_q       <= lfsr_d;
      card_q       <= card_d;
      card_valid_q <= card_valid_d;
      cards_left_q <= cards_left_d;
    end
  end

  // NOTE: the deck storage is deliberately not reset; FILL rewrites every
  // entry before any of them can be read.
  always_ff @(posedge clk) begin
    deck_q <= deck_d;
  end

  assign card       = card_q;
  assign card_valid = card_valid_q;
  assign cards_left = cards_left_q;
  assign ready      = (state_q == S_READY);
  assign empty      = ready && (cards_left_q == 8'd0);

endmodule

// File: tb/tb_card_dealer.sv
`timescale 1ns/1ps
module tb_card_dealer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the three single-deck instances
  logic reset = 1'b0, shuffle = 1'b0, draw = 1'b0, card_taken = 1'b0;
  // Stimulus for the four-deck instance
  logic reset4 = 1'b0, shuffle4 = 1'b0, draw4 = 1'b0, taken4 = 1'b0;

  logic [3:0] card1, card0, card01, card4;
  logic       valid1, valid0, valid01, valid4;
  logic       rdy1, rdy0, rdy01, rdy4;
  logic       empty1, empty0, empty01, empty4;
  logic [7:0] left1, left0, left01, left4;

  card_dealer #(.NUM_DECKS(1), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .shuffle(shuffle), .draw(draw), .card_taken(card_taken),
    .card(card1), .card_valid(valid1), .ready(rdy1), .empty(empty1), .cards_left(left1));

  card_dealer #(.NUM_DECKS(1), .SEED(16'h0000)) dut_seed0 (
    .clk(clk), .reset(reset), .shuffle(shuffle), .draw(draw), .card_taken(card_taken),
    .card(card0), .card_valid(valid0), .ready(rdy0), .empty(empty0), .cards_left(left0));

  card_dealer #(.NUM_DECKS(1), .SEED(16'h0001)) dut_seed1 (
    .clk(clk), .reset(reset), .shuffle(shuffle), .draw(draw), .card_taken(card_taken),
    .card(card01), .card_valid(valid01), .ready(rdy01), .empty(empty01), .cards_left(left01));

  card_dealer #(.NUM_DECKS(4), .SEED(16'hACE1)) dut_four (
    .clk(clk), .reset(reset4), .shuffle(shuffle4), .draw(draw4), .card_taken(taken4),
    .card(card4), .card_valid(valid4), .ready(rdy4), .empty(empty4), .cards_left(left4));

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] sb [$];
  logic [3:0] model_deck [208];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference shoe: fill then Fisher-Yates, one LFSR step per hardware cycle.
  task automatic build_model(input int n, input logic [15:0] seed);
    logic [15:0] l;
    logic [3:0]  t;
    int          j;
    l = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int i = 0; i < n; i++) begin
      model_deck[i] = ((i % 13) >= 9) ? 4'd10 : 4'((i % 13) + 1);
      l = lfsr_step(l);
    end
    for (int i = n - 1; i >= 1; i--) begin
      j = (int'(l[7:0]) * (i + 1)) >> 8;
      t = model_deck[i];
      model_deck[i] = model_deck[j];
      model_deck[j] = t;
      l = lfsr_step(l);
    end
  endtask

  task automatic wait_ready(input bit four, input int exp_cycles);
    int n;
    n = 0;
    while (!(four ? rdy4 : rdy1) && n < 1000) begin
      tick();
      n++;
    end
    check(four ? "ready_latency_4deck" : "ready_latency", n, exp_cycles);
  endtask

  // Deals the whole shoe; optionally checks against the model through the
  // scoreboard and exercises draw-while-valid on the first card.
  task automatic deal_shoe(input bit four, input bit use_sb, input bit do_t3);
    int n, nd;
    int tally [11];
    int tally0 [11];
    logic [3:0] c, e;
    nd = four ? 4 : 1;
    n  = 52 * nd;
    for (int v = 0; v < 11; v++) begin
      tally[v]  = 0;
      tally0[v] = 0;
    end
    for (int k = 0; k < n; k++) begin
      if (use_sb) sb.push_back(model_deck[k]);
      if (four) draw4 = 1'b1; else draw = 1'b1;
      tick();
      draw = 1'b0; draw4 = 1'b0;
      c = four ? card4 : card1;
      check("valid_after_draw", four ? valid4 : valid1, 1);
      check("cards_left_dec", four ? left4 : left1, n - 1 - k);
      if (use_sb) begin
        e = sb.pop_front();
        check("card_vs_model", c, e);
      end
      if (c >= 4'd1 && c <= 4'd10) tally[c]++;
      else check("card_range", c, 1);
      if (!four) begin
        check("seed0_vs_seed1", card0, card01);
        if (card0 >= 4'd1 && card0 <= 4'd10) tally0[card0]++;
      end
      if (do_t3 && k == 0) begin
        draw = 1'b1;
        tick();
        draw = 1'b0;
        check("draw_while_valid_card", card1, c);
        check("draw_while_valid_left", left1, n - 1);
        draw = 1'b1; card_taken = 1'b1;
        tick();
        draw = 1'b0; card_taken = 1'b0;
        check("draw_with_take_card", card1, 0);
        check("draw_with_take_valid", valid1, 0);
        check("draw_with_take_left", left1, n - 1);
      end else begin
        if (four) taken4 = 1'b1; else card_taken = 1'b1;
        tick();
        taken4 = 1'b0; card_taken = 1'b0;
        check("card_after_take", four ? card4 : card1, 0);
      end
    end
    for (int v = 1; v <= 10; v++) begin
      check(four ? "multiset_4deck" : "multiset", tally[v], (v == 10) ? 16 * nd : 4 * nd);
      if (!four) check("multiset_seed0", tally0[v], (v == 10) ? 16 : 4);
    end
    check("empty_after_shoe", four ? empty4 : empty1, 1);
    check("left_after_shoe", four ? left4 : left1, 0);
    if (four) draw4 = 1'b1; else draw = 1'b1;
    tick();
    draw = 1'b0; draw4 = 1'b0;
    check("draw_empty_card", four ? card4 : card1, 0);
    check("draw_empty_valid", four ? valid4 : valid1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset, then ready timing for one deck
    repeat (3) tick();
    check("reset_ready", rdy1, 0);
    check("reset_valid", valid1, 0);
    check("reset_card", card1, 0);
    check("reset_left", left1, 0);
    check("reset_empty", empty1, 0);
    reset = 1'b1;
    wait_ready(1'b0, 103);
    check("ready_seed0", rdy0, 1);
    check("ready_left", left1, 52);
    check("ready_card", card1, 0);
    check("ready_empty", empty1, 0);

    build_model(52, 16'hACE1);
    deal_shoe(1'b0, 1'b1, 1'b1);

    // Reset in the middle of SHUFFLE, then a second dealt run
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (70) tick();
    reset = 1'b0;
    tick();
    check("midreset_ready", rdy1, 0);
    check("midreset_valid", valid1, 0);
    check("midreset_card", card1, 0);
    check("midreset_left", left1, 0);
    check("midreset_empty", empty1, 0);
    reset = 1'b1;
    wait_ready(1'b0, 103);
    check("rerun_left", left1, 52);
    deal_shoe(1'b0, 1'b1, 1'b0);

    // Reshuffle from READY; LFSR runs on, so only timing and multiset checked
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    check("shuffle_ready_low", rdy1, 0);
    check("shuffle_left", left1, 0);
    wait_ready(1'b0, 103);
    check("reshuffle_left", left1, 52);
    deal_shoe(1'b0, 1'b0, 1'b0);

    // Four-deck shoe
    reset4 = 1'b1;
    wait_ready(1'b1, 415);
    check("ready_left_4deck", left4, 208);
    build_model(208, 16'hACE1);
    deal_shoe(1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
